// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Optional MDU_FAST_MUL_EN: multiplies use one combinational product.
module mdu_iterative #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [2:0]        r_op;
    logic              r_neg;
    logic              r_rneg;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_is_div;
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_spec_val;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_val;

    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_mul_acc;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_div_ok;
    logic [XLEN-1:0]   w_div_rem;
    logic [XLEN-1:0]   w_div_q;
    logic [2*XLEN-1:0] w_step_acc;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_remf;
    logic [XLEN-1:0]   w_final;

    assign w_accept = (r_state == S_IDLE) & start & ~flush;
    assign w_is_div = funct3[2];
    assign w_a_sgn  = (funct3 == 3'b001) | (funct3 == 3'b010)
                    | (funct3[2] & ~funct3[0]);
    assign w_b_sgn  = (funct3 == 3'b001) | (funct3[2] & ~funct3[0]);
    assign w_a_neg  = w_a_sgn & operand_a[XLEN-1];
    assign w_b_neg  = w_b_sgn & operand_b[XLEN-1];
    assign w_mag_a  = w_a_neg ? -operand_a : operand_a;
    assign w_mag_b  = w_b_neg ? -operand_b : operand_b;

    assign w_div0    = (operand_b == '0);
    assign w_ovf     = w_b_sgn & (operand_a == MIN_NEG)
                     & (operand_b == '1);
    assign w_special = w_is_div & (w_div0 | w_ovf);

    always_comb begin
        w_spec_val = '0;
        if (w_div0)
            w_spec_val = funct3[1] ? operand_a : '1;
        else
            w_spec_val = funct3[1] ? '0 : MIN_NEG;
    end

`ifdef MDU_FAST_MUL_EN
    logic signed [2*XLEN-1:0] w_fa;
    logic signed [2*XLEN-1:0] w_fb;
    logic signed [2*XLEN-1:0] w_fprod;

    assign w_fa       = {{XLEN{w_a_neg}}, operand_a};
    assign w_fb       = {{XLEN{w_b_neg}}, operand_b};
    assign w_fprod    = w_fa * w_fb;
    assign w_fast     = ~funct3[2];
    assign w_fast_val = (funct3 == 3'b000) ? w_fprod[XLEN-1:0]
                                           : w_fprod[2*XLEN-1:XLEN];
`else
    assign w_fast     = 1'b0;
    assign w_fast_val = '0;
`endif

    // multiply: add multiplicand into the high half, shift right
    assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]}
                     + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_mul_acc = {w_sum, r_acc[XLEN-1:1]};

    // divide: dividend shifts out of r_acc low half, quotient shifts in
    assign w_shift    = {r_rem, r_acc[XLEN-1]};
    assign w_diff     = w_shift - {1'b0, r_mcand};
    assign w_div_ok   = w_shift[XLEN] | ~w_diff[XLEN];
    assign w_div_rem  = w_div_ok ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_div_q    = {r_acc[XLEN-2:0], w_div_ok};
    assign w_step_acc = r_op[2] ? {r_acc[2*XLEN-1:XLEN], w_div_q}
                                : w_mul_acc;

    assign w_prod = r_neg  ? -w_mul_acc : w_mul_acc;
    assign w_quo  = r_neg  ? -w_div_q   : w_div_q;
    assign w_remf = r_rneg ? -w_div_rem : w_div_rem;

    always_comb begin
        w_final = '0;
        case (r_op)
            3'b000:                 w_final = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_quo;
            default:                w_final = w_remf;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start)
                        w_next = (w_special | w_fast) ? S_FINISH : S_COMPUTE;
                end
                S_COMPUTE: begin
                    if (r_cnt == CNT_W'(1))
                        w_next = S_FINISH;
                end
                S_FINISH: w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op   <= funct3;
            r_cnt  <= CNT_W'(XLEN);
            r_neg  <= w_a_neg ^ w_b_neg;
            r_rneg <= w_a_neg;
            r_rem  <= '0;
            if (w_is_div) begin
                r_mcand <= w_mag_b;
                r_acc   <= {{XLEN{1'b0}}, w_mag_a};
            end else begin
                r_mcand <= w_mag_a;
                r_acc   <= {{XLEN{1'b0}}, w_mag_b};
            end
            if (w_special)
                r_result <= w_spec_val;
            else if (w_fast)
                r_result <= w_fast_val;
        end else if ((r_state == S_COMPUTE) && !flush) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_acc <= w_step_acc;
            r_rem <= w_div_rem;
            if (r_cnt == CNT_W'(1))
                r_result <= w_final;
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_FINISH);
    assign result = r_result;

endmodule
